// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU: add/sub/and/or in one cycle, shift-add MUL, restoring DIV.
// Ports: clk, reset, start, ALUop, operand_a/b in; result, zero, busy, done out.
module alu_exec_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  ALUop,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [31:0] result,
  output logic        zero,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DIVFIX
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;

  state_t      state_q;
  logic        go_q;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] x_q;
  logic [31:0] y_q;
  logic [31:0] acc_q;
  logic        neg_q;
  logic [5:0]  cnt_q;
  logic [31:0] result_q;
  logic        busy_q;
  logic        done_q;

  logic        div_zero;
  logic        div_ovf;
  logic        long_op;
  logic        accept;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [31:0] mul_acc_d;
  logic [32:0] rem_sh;
  logic [32:0] rem_sub;
  logic        rem_ge;
  logic [31:0] quot_d;
  logic [31:0] rem_d;

  assign div_zero = (b_q == 32'h0);
  assign div_ovf  = (a_q == 32'h8000_0000)
                 && (b_q == 32'hFFFF_FFFF);

  // A captured MUL/DIV leaves IDLE on the next edge, so a start in that
  // cycle would be stranded; refuse it.
  assign long_op = go_q && (state_q == S_IDLE)
                && ((op_q == OP_MUL)
                 || ((op_q == OP_DIV) && !div_zero && !div_ovf));
  assign accept  = start && (state_q == S_IDLE) && !long_op;

  assign a_abs = a_q[31] ? (32'h0 - a_q) : a_q;
  assign b_abs = b_q[31] ? (32'h0 - b_q) : b_q;

  // x_q: multiplicand / divisor, y_q: multiplier / dividend->quotient,
  // acc_q: product accumulator / partial remainder.
  assign mul_acc_d = acc_q + (y_q[0] ? x_q : 32'h0);

  assign rem_sh  = {acc_q, y_q[31]};
  assign rem_sub = rem_sh - {1'b0, x_q};
  assign rem_ge  = ~rem_sub[32];
  assign quot_d  = {y_q[30:0], rem_ge};
  assign rem_d   = rem_ge ? rem_sub[31:0] : rem_sh[31:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      go_q     <= 1'b0;
      op_q     <= 3'b000;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      x_q      <= 32'h0;
      y_q      <= 32'h0;
      acc_q    <= 32'h0;
      neg_q    <= 1'b0;
      cnt_q    <= 6'd0;
      result_q <= 32'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      go_q   <= accept;
      if (accept) begin
        op_q <= ALUop;
        a_q  <= operand_a;
        b_q  <= operand_b;
      end
      unique case (state_q)
        S_IDLE: begin
          if (go_q) begin
            case (op_q)
              OP_ADD: begin
                result_q <= a_q + b_q;
                done_q   <= 1'b1;
              end
              OP_SUB: begin
                result_q <= a_q - b_q;
                done_q   <= 1'b1;
              end
              OP_AND: begin
                result_q <= a_q & b_q;
                done_q   <= 1'b1;
              end
              OP_OR: begin
                result_q <= a_q | b_q;
                done_q   <= 1'b1;
              end
              OP_MUL: begin
                x_q     <= a_q;
                y_q     <= b_q;
                acc_q   <= 32'h0;
                cnt_q   <= 6'd0;
                busy_q  <= 1'b1;
                state_q <= S_MUL;
              end
              OP_DIV: begin
                if (div_zero) begin
                  result_q <= 32'hFFFF_FFFF;
                  done_q   <= 1'b1;
                end else if (div_ovf) begin
                  result_q <= 32'h8000_0000;
                  done_q   <= 1'b1;
                end else begin
                  x_q     <= b_abs;
                  y_q     <= a_abs;
                  acc_q   <= 32'h0;
                  neg_q   <= a_q[31] ^ b_q[31];
                  cnt_q   <= 6'd0;
                  busy_q  <= 1'b1;
                  state_q <= S_DIV;
                end
              end
              default: begin
                result_q <= 32'h0;
                done_q   <= 1'b1;
              end
            endcase
          end
        end
        S_MUL: begin
          acc_q <= mul_acc_d;
          x_q   <= x_q << 1;
          y_q   <= y_q >> 1;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            result_q <= mul_acc_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            cnt_q    <= 6'd0;
            state_q  <= S_IDLE;
          end
        end
        S_DIV: begin
          acc_q <= rem_d;
          y_q   <= quot_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            cnt_q   <= 6'd0;
            state_q <= S_DIVFIX;
          end
        end
        S_DIVFIX: begin
          result_q <= neg_q ? (32'h0 - y_q) : y_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign result = result_q;
  assign zero   = (result_q == 32'h0);
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
